// File: rtl/rv32i_inst_encoder_if.sv
// Field-bundle and encoded-word stream between a producer, the RV32I encoder and
// its consumer. The encoder connects through the slave modport, the producer and
// consumer through the master modport.
interface rv32i_inst_encoder_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_fmt;
  logic [6:0]            in_opcode;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [2:0]            in_funct3;
  logic [6:0]            in_funct7;
  logic [31:0]           in_imm;
  logic                  in_last;

  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_inst;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_err;
  logic                  out_last;
  logic                  err_sticky;
  logic [ADDR_WIDTH:0]   word_count;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, out_last, err_sticky,
           word_count
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
           in_imm, in_last, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, out_last, err_sticky,
           word_count
  );
endinterface

// File: rtl/rv32i_inst_encoder.sv
// Streaming RV32I instruction encoder: packs decoded fields into 32-bit words with
// per-format immediate scrambling, flags out-of-range immediates and tags each word
// with a word address. One output register stage, 1 word/clk throughput.
module rv32i_inst_encoder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned BASE_ADDR  = 0
) (
  input logic                 clk,
  input logic                 rst,
  rv32i_inst_encoder_if.slave bus
);
  localparam logic [2:0] FmtR = 3'd0;
  localparam logic [2:0] FmtI = 3'd1;
  localparam logic [2:0] FmtS = 3'd2;
  localparam logic [2:0] FmtB = 3'd3;
  localparam logic [2:0] FmtU = 3'd4;
  localparam logic [2:0] FmtJ = 3'd5;

  localparam logic [31:0]         Nop      = 32'h0000_0013;
  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] CountMax = '1;

  logic                  valid_q;
  logic [31:0]           inst_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  err_q;
  logic                  last_q;
  logic                  sticky_q;
  logic [ADDR_WIDTH:0]   count_q;

  logic        in_xfer;
  logic        out_xfer;
  logic [31:0] inst_enc;
  logic        err_enc;
  logic [31:0] imm;

  assign imm          = bus.in_imm;
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign in_xfer      = bus.in_valid && bus.in_ready;
  assign out_xfer     = valid_q && bus.out_ready;

  // Pack fields per format; the immediate must survive the truncation unchanged.
  always_comb begin
    inst_enc = Nop;
    err_enc  = 1'b1;
    case (bus.in_fmt)
      FmtR: begin
        inst_enc = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                    bus.in_opcode};
        err_enc  = 1'b0;
      end
      FmtI: begin
        inst_enc = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
        err_enc  = imm[31:11] != {21{imm[11]}};
      end
      FmtS: begin
        inst_enc = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0],
                    bus.in_opcode};
        err_enc  = imm[31:11] != {21{imm[11]}};
      end
      FmtB: begin
        inst_enc = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1],
                    imm[11], bus.in_opcode};
        err_enc  = (imm[31:12] != {20{imm[12]}}) || imm[0];
      end
      FmtU: begin
        inst_enc = {imm[31:12], bus.in_rd, bus.in_opcode};
        err_enc  = imm[11:0] != 12'd0;
      end
      FmtJ: begin
        inst_enc = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
        err_enc  = (imm[31:20] != {12{imm[20]}}) || imm[0];
      end
      default: begin
        inst_enc = Nop;
        err_enc  = 1'b1;
      end
    endcase
  end

  // Output register: reload on accept, drain on transfer, hold under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      inst_q  <= inst_enc;
      err_q   <= err_enc;
      last_q  <= bus.in_last;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end

  // Address and statistics advance only on output transfers. addr_q only moves when
  // the held word leaves, so a word loaded in the same cycle picks up the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= BaseAddr;
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else if (out_xfer) begin
      addr_q   <= last_q ? BaseAddr : addr_q + ADDR_WIDTH'(1);
      sticky_q <= sticky_q || err_q;
      if (count_q != CountMax) begin
        count_q <= count_q + (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_inst   = inst_q;
  assign bus.out_addr   = addr_q;
  assign bus.out_err    = err_q;
  assign bus.out_last   = last_q;
  assign bus.err_sticky = sticky_q;
  assign bus.word_count = count_q;
endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Scoreboard bench for rv32i_inst_encoder: expected words are queued when the input
// handshake is seen and compared whenever the encoder presents a word.
module tb_rv32i_inst_encoder;
  localparam int unsigned AW   = 2;
  localparam int unsigned BASE = 1;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_inst_encoder_if #(.ADDR_WIDTH(AW)) bus ();

  rv32i_inst_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  int   m_addr   = BASE;
  int   m_count  = 0;
  bit   m_sticky = 1'b0;
  bit   rnd_bp   = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endfunction

  // Reference encoder written from the format rules with shifts and range checks.
  function automatic exp_t model(logic [31:0] fmt, logic [31:0] op, logic [31:0] rd,
                                 logic [31:0] rs1, logic [31:0] rs2, logic [31:0] f3,
                                 logic [31:0] f7, logic [31:0] imm, bit last);
    exp_t   e;
    longint s;
    s      = longint'($signed(imm));
    e.last = last;
    e.err  = 1'b0;
    case (fmt)
      0: e.inst = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      1: begin
        e.inst = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        e.err  = (s < -2048) || (s > 2047);
      end
      2: begin
        e.inst = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
               | ((imm & 32'h1F) << 7) | op;
        e.err  = (s < -2048) || (s > 2047);
      end
      3: begin
        e.inst = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
               | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
               | (((imm >> 11) & 1) << 7) | op;
        e.err  = (s < -4096) || (s > 4095) || (imm % 2 != 0);
      end
      4: begin
        e.inst = (imm & 32'hFFFF_F000) | (rd << 7) | op;
        e.err  = (imm % 4096) != 0;
      end
      5: begin
        e.inst = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
               | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
        e.err  = (s < -1048576) || (s > 1048575) || (imm % 2 != 0);
      end
      default: begin
        e.inst = 32'h0000_0013;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Monitor: check the presented word against the queue head, then record new accepts.
  always @(negedge clk) begin
    bit   exp_v;
    exp_t e;
    if (rst) begin
      q.delete();
      m_addr   = BASE;
      m_count  = 0;
      m_sticky = 1'b0;
    end else begin
      exp_v = q.size() != 0;
      chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
      chk("in_ready", 32'(bus.in_ready), 32'(!exp_v || bus.out_ready));
      chk("word_count", 32'(bus.word_count), 32'(m_count));
      chk("err_sticky", 32'(bus.err_sticky), 32'(m_sticky));
      if (exp_v) begin
        e = q[0];
        chk("out_inst", bus.out_inst, e.inst);
        chk("out_err", 32'(bus.out_err), 32'(e.err));
        chk("out_last", 32'(bus.out_last), 32'(e.last));
        chk("out_addr", 32'(bus.out_addr), 32'(m_addr));
        if (bus.out_ready) begin
          void'(q.pop_front());
          m_addr   = e.last ? BASE : (m_addr + 1) % (1 << AW);
          if (m_count < (1 << (AW + 1)) - 1) m_count = m_count + 1;
          m_sticky = m_sticky || e.err;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(model(32'(bus.in_fmt), 32'(bus.in_opcode), 32'(bus.in_rd),
                          32'(bus.in_rs1), 32'(bus.in_rs2), 32'(bus.in_funct3),
                          32'(bus.in_funct7), bus.in_imm, bus.in_last));
      end
    end
  end

  // Random backpressure while enabled.
  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      bus.out_ready = $urandom_range(0, 3) != 0;
    end
  end

  task automatic send(input int fmt, input int op, input int rd, input int rs1,
                      input int rs2, input int f3, input int f7, input logic [31:0] imm,
                      input bit last);
    int guard;
    guard          = 0;
    bus.in_valid   = 1'b1;
    bus.in_fmt     = 3'(fmt);
    bus.in_opcode  = 7'(op);
    bus.in_rd      = 5'(rd);
    bus.in_rs1     = 5'(rs1);
    bus.in_rs2     = 5'(rs2);
    bus.in_funct3  = 3'(f3);
    bus.in_funct7  = 7'(f7);
    bus.in_imm     = imm;
    bus.in_last    = last;
    @(negedge clk);
    while (!bus.in_ready && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1 within 500 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int          v;
    logic [31:0] imm;
    int          guard;
    bus.in_valid  = 1'b0;
    bus.in_fmt    = '0;
    bus.in_opcode = '0;
    bus.in_rd     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_funct3 = '0;
    bus.in_funct7 = '0;
    bus.in_imm    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_addr", 32'(bus.out_addr), BASE);
    chk("rst_out_inst", bus.out_inst, 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
    chk("rst_word_count", 32'(bus.word_count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ADDI x1, x0, 5
    send(1, 'h13, 1, 0, 0, 0, 0, 32'd5, 1'b0);
    idle_cycles(2);

    // SW, BEQ, JAL, LUI back to back
    send(2, 'h23, 0, 1, 2, 2, 0, 32'd8, 1'b0);
    send(3, 'h63, 0, 1, 2, 0, 0, -32'sd4, 1'b0);
    send(5, 'h6F, 1, 0, 0, 0, 0, 32'd8, 1'b0);
    send(4, 'h37, 5, 0, 0, 0, 0, 32'h1234_5000, 1'b0);
    idle_cycles(2);

    // Immediate and format errors, then clean words with err_sticky held
    send(1, 'h13, 3, 4, 0, 0, 0, 32'd2048, 1'b0);
    send(3, 'h63, 0, 5, 6, 1, 0, 32'd6, 1'b0);
    send(3, 'h63, 0, 5, 6, 1, 0, 32'd7, 1'b0);
    send(7, 'h33, 1, 2, 3, 0, 0, 32'd0, 1'b0);
    send(0, 'h33, 7, 8, 9, 0, 'h20, 32'hFFFF_FFFF, 1'b0);
    send(1, 'h13, 2, 2, 0, 0, 0, -32'sd2048, 1'b1);
    idle_cycles(2);

    // Backpressure: one word held for several cycles, next word queued behind it
    bus.out_ready = 1'b0;
    send(1, 'h13, 10, 11, 0, 6, 0, 32'd100, 1'b0);
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join_none
    send(2, 'h23, 0, 12, 13, 0, 0, -32'sd1, 1'b0);
    idle_cycles(2);

    // Address wrap and in_last reload
    for (int i = 0; i < 5; i++) send(1, 'h13, i, 0, 0, 0, 0, 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) send(0, 'h33, i, i, i, 0, 0, 32'd0, i == 1);
    idle_cycles(2);

    // Reset while a word is stalled
    bus.out_ready = 1'b0;
    send(1, 'h13, 1, 1, 0, 0, 0, 32'd4096, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_addr", 32'(bus.out_addr), BASE);
    chk("midrst_word_count", 32'(bus.word_count), 32'd0);
    chk("midrst_err_sticky", 32'(bus.err_sticky), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Randomized stream with random backpressure and input gaps
    rnd_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: imm = $urandom;
        1: begin v = int'($urandom_range(0, 8191)) - 4096; imm = 32'(v); end
        2: begin v = int'($urandom_range(0, 4095)) - 2048; imm = 32'(v * 2); end
        3: imm = $urandom & 32'hFFFF_F000;
        default: begin v = int'($urandom_range(0, 4194303)) - 2097152; imm = 32'(v); end
      endcase
      send(int'($urandom_range(0, 7)), int'($urandom_range(0, 127)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 127)), imm, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      guard++;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d words still pending, expected 0", q.size());
    end
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32i_inst_encoder.md
Name: rv32i_inst_encoder

Overview:
- Streaming RV32I instruction encoder, the inverse of the instruction decode path.
- Accepts decoded fields (format, opcode, registers, functs, full 32-bit immediate) over a valid/ready handshake.
- Packs them into 32-bit instruction words with the RV32I per-format immediate scrambling, range-checks the immediate, and tags each word with a word address.
- Feeds the instruction-RAM loader and the self-test program generator.

Parameters:
- ADDR_WIDTH, 10, width of the output word-address counter; wraps at 2^ADDR_WIDTH.
- BASE_ADDR, 0, word address of the first word after reset and after each out_last transfer.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input field bundle valid
- in_ready  out  1  encoder can accept the bundle
- in_fmt  in  3  format code: RTYPE=0, ITYPE=1, STYPE=2, BTYPE=3, UTYPE=4, JTYPE=5; 6 and 7 are illegal
- in_opcode  in  7  opcode field, copied verbatim
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_funct3  in  3  funct3
- in_funct7  in  7  funct7, used by R only
- in_imm  in  32  immediate as a byte offset or value; U format takes the full value
- in_last  in  1  marks the final word of a program
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts the word
- out_inst  out  32  encoded instruction
- out_addr  out  ADDR_WIDTH  word address of out_inst
- out_err  out  1  this word failed its immediate/format check
- out_last  out  1  registered copy of in_last
- err_sticky  out  1  set by any out_err transfer; cleared only by rst
- word_count  out  ADDR_WIDTH+1  total words transferred since rst; saturates at all-ones

Behaviour:
- Reset: clk and rst are the only clock/reset; reset is synchronous, active-high. On rst, all outputs are 0, except out_addr=BASE_ADDR and in_ready=1.
- Single output register stage.
  - in_ready = !out_valid || out_ready, combinational.
  - Input transfer occurs when in_valid && in_ready.
  - out_valid rises the cycle after the input transfer: latency 1, throughput 1 word/clk.
- While out_valid && !out_ready, out_inst/out_addr/out_err/out_last hold stable.
- Simultaneous output and input transfer in one cycle: the register reloads with the new word; out_valid stays 1 with no bubble.
- Encoding, bit-exact:
  - R = {funct7, rs2, rs1, funct3, rd, opcode}
  - I = {imm[11:0], rs1, funct3, rd, opcode}
  - S = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U = {imm[31:12], rd, opcode}
  - J = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Error check, per format; out_err=1 when the check fails:
  - I, S: imm must sign-extend from bit 11.
  - B: imm must sign-extend from bit 12, and imm[0]=0.
  - J: imm must sign-extend from bit 20, and imm[0]=0.
  - U: imm[11:0]=0.
  - R: imm is ignored; never errs on imm.
  - in_fmt 6 or 7: always errs, and out_inst=32'h0000_0013 (NOP).
  - Erroneous words are still emitted, truncated per the formula above.
- Address counter: advances by 1 on each output transfer (out_valid && out_ready).
  - Wraps 2^ADDR_WIDTH-1 -> 0.
  - An output transfer with out_last=1 loads BASE_ADDR instead of incrementing.
  - out_addr is the address of the word currently held, sampled at load time.
- word_count and err_sticky update on output transfers only.
- Reset mid-operation: a pending out_valid word is dropped, not retried.

Test Plan:
- ITYPE, opcode 0x13, rd=1, rs1=0, f3=0, imm=5 -> out_inst=0x00500093, out_err=0, out_addr=0, out_valid exactly 1 cycle after accept.
- Back-to-back stream of four words with out_ready=1:
  - SW (STYPE 0x23, rs1=1, rs2=2, f3=2, imm=8) -> 0x0020A423.
  - BEQ (BTYPE 0x63, rs1=1, rs2=2, imm=-4) -> 0xFE208EE3.
  - JAL (JTYPE 0x6F, rd=1, imm=8) -> 0x008000EF.
  - LUI (UTYPE 0x37, rd=5, imm=0x12345000) -> 0x123452B7.
  - Required: out_addr 0,1,2,3; word_count=4; no bubbles.
- Errors:
  - ITYPE imm=2048 -> out_err=1, err_sticky=1.
  - BTYPE imm=6 passes; BTYPE imm=7 errs.
  - in_fmt=7 -> out_inst=0x00000013, out_err=1.
  - err_sticky stays 1 through later clean words.
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 -> in_ready=0 and outputs stable; on release, the next word follows with no bubble.
- Address behaviour:
  - With ADDR_WIDTH=2: 5 words -> out_addr 0,1,2,3,0.
  - in_last on word 2 -> the next word's out_addr=BASE_ADDR.
- Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_addr=BASE_ADDR, word_count=0, err_sticky=0.
